btn_conditioner: RTL and testbench

- Front-end input stage that sits directly upstream of the player and blade logic.
- Synchronises and debounces the raw push-buttons BtnL, BtnR and BtnD in the 100 MHz clk domain.
- Converts presses into events aligned to sim_clk ticks, so the game-tick logic never misses a short press.
- Measures how long the jump button is held and reports a saturating charge value on release (charge jump).

---
 rtl/sk_pkg.sv | 17 +
 rtl/btn_conditioner_if.sv | 23 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/btn_conditioner.sv | 138 +++++++++++++
 tb/tb_btn_conditioner.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/sk_pkg.sv
// Shared constants for the button front end: button indices, charge FSM
// encoding and the default debounce interval.
package sk_pkg;

  localparam int BTN_JUMP  = 0;
  localparam int BTN_SHOOT = 1;
  localparam int BTN_RST   = 2;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef logic [1:0] chg_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHARGE  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle of the tick input, raw buttons and all conditioned button outputs.
interface btn_conditioner_if #(
  parameter int N_BTN    = 3,
  parameter int CHARGE_W = 5
);
  logic                sim_clk;
  logic [N_BTN-1:0]    btn_raw;
  logic [N_BTN-1:0]    btn_level;
  logic [N_BTN-1:0]    btn_press;
  logic                jump_fire;
  logic [CHARGE_W-1:0] jump_charge;
  logic                charging;

  modport master (
    output sim_clk, btn_raw,
    input  btn_level, btn_press, jump_fire, jump_charge, charging
  );

  modport slave (
    input  sim_clk, btn_raw,
    output btn_level, btn_press, jump_fire, jump_charge, charging
  );
endinterface

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchroniser followed by a stability counter that
// only flips the accepted level after DEBOUNCE_CYCLES consecutive mismatches.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where sync agrees with the level restarts the count.
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/btn_conditioner.sv
// Debounces the buttons, re-times press events onto sim_clk ticks and measures
// the jump hold time in ticks for the charge jump.
module btn_conditioner
  import sk_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20,
  parameter int CHARGE_W        = 5,
  parameter int CHARGE_MAX      = 31
) (
  input  logic               clk,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);
  logic [N_BTN-1:0]    level;
  logic [N_BTN-1:0]    rise;
  logic                tick;
  logic                jump_fall;

  logic                sim_clk_q, sim_clk_d;
  logic [N_BTN-1:0]    level_prev_q, level_prev_d;
  logic [N_BTN-1:0]    pend_q, pend_d;
  logic [N_BTN-1:0]    press_q, press_d;
  chg_state_t          state_q, state_d;
  logic [CHARGE_W-1:0] chg_cnt_q, chg_cnt_d;
  logic [CHARGE_W-1:0] rel_val_q, rel_val_d;
  logic [CHARGE_W-1:0] charge_out_q, charge_out_d;
  logic                fire_q, fire_d;
  logic                rise_hold_q, rise_hold_d;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.btn_raw[gi]),
      .level(level[gi])
    );
  end

  always_comb begin
    tick         = bus.sim_clk & ~sim_clk_q;
    rise         = level & ~level_prev_q;
    jump_fall    = ~level[BTN_JUMP] & level_prev_q[BTN_JUMP];
    sim_clk_d    = bus.sim_clk;
    level_prev_d = level;

    // A rise in the tick cycle itself lands in pend for the following tick.
    press_d = press_q;
    pend_d  = pend_q | rise;
    if (tick) begin
      press_d = pend_q;
      pend_d  = rise;
    end

    state_d      = state_q;
    chg_cnt_d    = chg_cnt_q;
    rel_val_d    = rel_val_q;
    fire_d       = fire_q;
    charge_out_d = charge_out_q;
    rise_hold_d  = rise_hold_q;
    if (tick) begin
      fire_d       = 1'b0;
      charge_out_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise[BTN_JUMP]) begin
          state_d   = ST_CHARGE;
          chg_cnt_d = '0;
        end
      end
      ST_CHARGE: begin
        if (tick && chg_cnt_q != CHARGE_W'(CHARGE_MAX)) begin
          chg_cnt_d = chg_cnt_q + CHARGE_W'(1);
        end
        // Latch the post-increment value so a coincident tick is counted.
        if (jump_fall) begin
          rel_val_d = chg_cnt_d;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rise[BTN_JUMP]) begin
          rise_hold_d = 1'b1;
        end
        if (tick) begin
          fire_d       = 1'b1;
          charge_out_d = rel_val_q;
          rise_hold_d  = 1'b0;
          if (rise_hold_q || rise[BTN_JUMP]) begin
            state_d   = ST_CHARGE;
            chg_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sim_clk_q    <= 1'b0;
      level_prev_q <= '0;
      pend_q       <= '0;
      press_q      <= '0;
      state_q      <= ST_IDLE;
      chg_cnt_q    <= '0;
      rel_val_q    <= '0;
      charge_out_q <= '0;
      fire_q       <= 1'b0;
      rise_hold_q  <= 1'b0;
    end else begin
      sim_clk_q    <= sim_clk_d;
      level_prev_q <= level_prev_d;
      pend_q       <= pend_d;
      press_q      <= press_d;
      state_q      <= state_d;
      chg_cnt_q    <= chg_cnt_d;
      rel_val_q    <= rel_val_d;
      charge_out_q <= charge_out_d;
      fire_q       <= fire_d;
      rise_hold_q  <= rise_hold_d;
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press_q;
  assign bus.jump_fire   = fire_q;
  assign bus.jump_charge = charge_out_q;
  assign bus.charging    = (state_q == ST_CHARGE);
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench: debounce 4, sim_clk period 20 clk; ticks register on the
// clk edge that ends every cycle whose index is a multiple of 20.
module tb_btn_conditioner;
  import sk_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   passes;
  int   fails;
  logic seen_fire;
  logic seen_charging;

  btn_conditioner_if #(.N_BTN(3), .CHARGE_W(5)) bus ();

  btn_conditioner #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .CHARGE_W       (5),
    .CHARGE_MAX     (31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clk; inputs written after this return are sampled at the
  // edge that ends cycle cyc.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.sim_clk = ((cyc % 20) < 10);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0;
    seen_fire = 1'b0; seen_charging = 1'b0;
    reset = 1'b1;
    bus.sim_clk = 1'b0;
    bus.btn_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level",    32'(bus.btn_level),   32'd0);
    chk("rst_press",    32'(bus.btn_press),   32'd0);
    chk("rst_fire",     32'(bus.jump_fire),   32'd0);
    chk("rst_charge",   32'(bus.jump_charge), 32'd0);
    chk("rst_charging", 32'(bus.charging),    32'd0);
    reset = 1'b0;

    // Debounce latency: level follows 6 cycles after the raw change.
    run_to(23); bus.btn_raw[BTN_SHOOT] = 1'b1;
    run_to(28); chk("db_lat_early", 32'(bus.btn_level[BTN_SHOOT]), 32'd0);
    run_to(29); chk("db_lat_exact", 32'(bus.btn_level[BTN_SHOOT]), 32'd1);
    run_to(33); bus.btn_raw[BTN_SHOOT] = 1'b0;

    // Press aligned to the next tick, held one full tick period.
    run_to(40); chk("press_before_tick", 32'(bus.btn_press[BTN_SHOOT]), 32'd0);
    run_to(41); chk("press_at_tick",     32'(bus.btn_press[BTN_SHOOT]), 32'd1);
    run_to(60); chk("press_held",        32'(bus.btn_press[BTN_SHOOT]), 32'd1);
    run_to(61); chk("press_drop",        32'(bus.btn_press[BTN_SHOOT]), 32'd0);

    // 3-cycle glitch is rejected.
    run_to(63); bus.btn_raw[BTN_SHOOT] = 1'b1;
    run_to(66); bus.btn_raw[BTN_SHOOT] = 1'b0;
    run_to(68); chk("glitch_level_a", 32'(bus.btn_level[BTN_SHOOT]), 32'd0);
    run_to(75); chk("glitch_level_b", 32'(bus.btn_level[BTN_SHOOT]), 32'd0);

    // Two presses inside one tick window collapse into one event.
    run_to(81); chk("glitch_no_press", 32'(bus.btn_press[BTN_SHOOT]), 32'd0);
    bus.btn_raw[BTN_SHOOT] = 1'b1;
    run_to(86); bus.btn_raw[BTN_SHOOT] = 1'b0;
    run_to(87); chk("dbl_first_level", 32'(bus.btn_level[BTN_SHOOT]), 32'd1);
    run_to(92); bus.btn_raw[BTN_SHOOT] = 1'b1;
    run_to(97); bus.btn_raw[BTN_SHOOT] = 1'b0;
    run_to(101); chk("dbl_press_on",   32'(bus.btn_press[BTN_SHOOT]), 32'd1);
    run_to(120); chk("dbl_press_held", 32'(bus.btn_press[BTN_SHOOT]), 32'd1);
    run_to(121); chk("dbl_press_off",  32'(bus.btn_press[BTN_SHOOT]), 32'd0);
    run_to(141); chk("dbl_single",     32'(bus.btn_press[BTN_SHOOT]), 32'd0);

    // Charge across 7 ticks.
    bus.btn_raw[BTN_JUMP] = 1'b1;
    run_to(148); chk("chg7_charging_start", 32'(bus.charging), 32'd1);
    run_to(200); chk("chg7_charging_mid",   32'(bus.charging), 32'd1);
    run_to(281); bus.btn_raw[BTN_JUMP] = 1'b0;
    run_to(287); chk("chg7_charging_last",  32'(bus.charging), 32'd1);
    run_to(288); chk("chg7_charging_off",   32'(bus.charging), 32'd0);
    run_to(300); chk("chg7_fire_wait",      32'(bus.jump_fire), 32'd0);
    run_to(301); chk("chg7_fire",           32'(bus.jump_fire), 32'd1);
                 chk("chg7_value",          32'(bus.jump_charge), 32'd7);
    run_to(320); chk("chg7_fire_held",      32'(bus.jump_fire), 32'd1);
                 chk("chg7_value_held",     32'(bus.jump_charge), 32'd7);
    run_to(321); chk("chg7_fire_clear",     32'(bus.jump_fire), 32'd0);
                 chk("chg7_value_clear",    32'(bus.jump_charge), 32'd0);

    // Saturation across 40 ticks.
    bus.btn_raw[BTN_JUMP] = 1'b1;
    run_to(1121); bus.btn_raw[BTN_JUMP] = 1'b0;
    run_to(1141); chk("sat_fire",  32'(bus.jump_fire),   32'd1);
                  chk("sat_value", 32'(bus.jump_charge), 32'd31);

    // Fall in the tick cycle after 3 ticks counts that tick.
    run_to(1161); bus.btn_raw[BTN_JUMP] = 1'b1;
    run_to(1234); bus.btn_raw[BTN_JUMP] = 1'b0;
    run_to(1240); chk("coin_charging", 32'(bus.charging),    32'd1);
    run_to(1261); chk("coin_fire",     32'(bus.jump_fire),   32'd1);
                  chk("coin_value",    32'(bus.jump_charge), 32'd4);

    // Reset mid-charge after 5 ticks.
    run_to(1281); bus.btn_raw[BTN_JUMP] = 1'b1;
    run_to(1390); chk("rmc_charging_before", 32'(bus.charging), 32'd1);
                  chk("rmc_level_before",    32'(bus.btn_level[BTN_JUMP]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rmc_level",    32'(bus.btn_level),   32'd0);
    chk("rmc_press",    32'(bus.btn_press),   32'd0);
    chk("rmc_fire",     32'(bus.jump_fire),   32'd0);
    chk("rmc_charge",   32'(bus.jump_charge), 32'd0);
    chk("rmc_charging", 32'(bus.charging),    32'd0);
    bus.btn_raw[BTN_JUMP] = 1'b0;
    bus.btn_raw[BTN_RST]  = 1'b0;
    run_to(1395); reset = 1'b0;
    while (cyc < 1461) begin
      step();
      seen_fire     = seen_fire | bus.jump_fire;
      seen_charging = seen_charging | bus.charging;
    end
    chk("rmc_no_fire_after",     32'(seen_fire),          32'd0);
    chk("rmc_no_charging_after", 32'(seen_charging),      32'd0);
    chk("rmc_no_press_after",    32'(bus.btn_press),      32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
